// File: rtl/inv_sub_bytes_seq_pkg.sv
// Shared AES definitions: state layout, FSM encodings and both S-box tables.
package inv_sub_bytes_seq_pkg;

    // 16 x 8-bit AES state. Byte k of the state (byte 0 = bits [127:120])
    // lives in element 15-k, so a plain 128-bit assignment keeps byte order.
    typedef logic [15:0][7:0] aes_state_t;

    // FSM encodings.
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_RUN  = 2'd1;
    localparam fsm_state_t ST_DONE = 2'd2;

    // Inverse S-box, indexed by the input byte.
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Forward S-box, kept beside the inverse so both directions share one source.
    localparam logic [7:0] FWD_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Inverse S-box lookup of a single byte.
    function automatic logic [7:0] inv_sbox_lut(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_inv_sbox.sv
// Combinational inverse S-box: one byte in, one byte out.
module inv_sub_bytes_seq_inv_sbox
    import inv_sub_bytes_seq_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    // Straight table lookup.
    always_comb begin
        byte_o = inv_sbox_lut(byte_i);
    end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES inverse SubBytes: LANES bytes per cycle, MSB byte group first.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// in_ready is high only in IDLE; out_valid is high only in DONE, and out_data
// (the work register itself) does not change while out_valid && !out_ready.
// Accept and release never coincide: in_ready rises the cycle after release.
module inv_sub_bytes_seq
    import inv_sub_bytes_seq_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    fsm_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    aes_state_t  work_q, work_d;
    logic        busy_q;

    logic [7:0]  lane_in  [LANES];
    logic [7:0]  lane_out [LANES];

    // Shared inverse S-box lanes.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        inv_sub_bytes_seq_inv_sbox u_sbox (
            .byte_i (lane_in[l]),
            .byte_o (lane_out[l])
        );
    end

    // Select the byte group addressed by cnt into the S-box lanes.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = 8'h00;
        end
        for (int g = 0; g < N; g++) begin
            if (cnt_q == CW'(g)) begin
                for (int l = 0; l < LANES; l++) begin
                    lane_in[l] = work_q[15 - (g * LANES + l)];
                end
            end
        end
    end

    // Next-state, counter and work-register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = aes_state_t'(in_data);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int g = 0; g < N; g++) begin
                    if (cnt_q == CW'(g)) begin
                        for (int l = 0; l < LANES; l++) begin
                            work_d[15 - (g * LANES + l)] = lane_out[l];
                        end
                    end
                end
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Outputs come from registers only.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        out_data  = work_q;
        busy      = busy_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: five instances (LANES = 1,2,4,8,16) share one
// input stream; LANES=4 (index 2) is the primary instance.
module tb_inv_sub_bytes_seq;
    import inv_sub_bytes_seq_pkg::*;

    localparam int NI = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] in_data = '0;
    logic [NI-1:0] in_ready_w, out_valid_w, busy_w;
    logic [127:0] out_data_w [NI];
    logic [1:0]   dbg_w [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        inv_sub_bytes_seq #(.LANES(1 << gi)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[gi]),
            .in_data   (in_data),
            .out_valid (out_valid_w[gi]),
            .out_ready (out_ready),
            .out_data  (out_data_w[gi]),
            .busy      (busy_w[gi]),
            .dbg_state (dbg_w[gi])
        );
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] fwd_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8 * i -: 8] = FWD_SBOX[s[127 - 8 * i -: 8]];
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_all_idle();
        int t = 0;
        while (!(&in_ready_w) && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", 128'(&in_ready_w), 128'(1'b1));
    endtask

    // Called on the negedge right after the accept edge (k = 0).
    task automatic collect(input logic [127:0] exp, input string tag);
        int lat [NI];
        int nval [NI];
        logic [127:0] got [NI];
        logic all_seen;
        for (int i = 0; i < NI; i++) begin
            lat[i] = -1;
            nval[i] = 0;
            got[i] = 'x;
        end
        check({tag, "_busy_k0"}, 128'(busy_w), 128'({NI{1'b1}}));
        check({tag, "_inrdy_k0"}, 128'(in_ready_w), 128'(0));
        check({tag, "_dbg_run"}, 128'(dbg_w[2]), 128'(2'd1));
        for (int k = 0; k <= 40; k++) begin
            all_seen = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (out_valid_w[i]) begin
                    if (nval[i] == 0) begin
                        lat[i] = k;
                        got[i] = out_data_w[i];
                    end
                    nval[i]++;
                end
                if (nval[i] == 0) all_seen = 1'b0;
            end
            if (all_seen && k >= 18) break;
            @(negedge clk);
        end
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s_data_L%0d", tag, 1 << i), got[i], exp);
            check($sformatf("%s_lat_L%0d", tag, 1 << i), 128'(lat[i]), 128'(16 >> i));
            check($sformatf("%s_once_L%0d", tag, 1 << i), 128'(nval[i]), 128'(1));
        end
    endtask

    task automatic send_check(input logic [127:0] din, input logic [127:0] exp, input string tag);
        wait_all_idle();
        out_ready = 1'b1;
        in_data = din;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        collect(exp, tag);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [6];

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] orig, a_exp, b_in, b_exp;
        int rx, sent, cyc, last_acc;
        logic pending;
        int nv [NI];

        vecs[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
        vecs[1] = '{128'h0, {16{8'h52}}};
        vecs[2] = '{{16{8'h63}}, 128'h0};
        vecs[3] = '{{16{8'h16}}, {16{8'hff}}};
        vecs[4] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb};
        vecs[5] = '{{16{8'h52}}, {16{8'h48}}};

        // Reset values.
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_inrdy_L%0d", 1 << i), 128'(in_ready_w[i]), 128'(1));
            check($sformatf("rst_outv_L%0d", 1 << i), 128'(out_valid_w[i]), 128'(0));
            check($sformatf("rst_data_L%0d", 1 << i), out_data_w[i], 128'h0);
            check($sformatf("rst_busy_L%0d", 1 << i), 128'(busy_w[i]), 128'(0));
            check($sformatf("rst_dbg_L%0d", 1 << i), 128'(dbg_w[i]), 128'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int v = 0; v < 6; v++) begin
            send_check(vecs[v].din, vecs[v].exp, $sformatf("vec%0d", v));
        end

        // Backpressure: hold out_ready low in DONE, offer a second state meanwhile.
        a_exp = {16{8'hff}};
        b_in  = 128'hd42711aee0bf98f1b8b45de51e415230;
        b_exp = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        wait_all_idle();
        out_ready = 1'b0;
        in_data = {16{8'h16}};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (16) @(negedge clk);
        in_data = b_in;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("bp_outv_c%0d", c), 128'(out_valid_w), 128'({NI{1'b1}}));
            check($sformatf("bp_inrdy_c%0d", c), 128'(in_ready_w), 128'(0));
            check($sformatf("bp_data4_c%0d", c), out_data_w[2], a_exp);
            check($sformatf("bp_data1_c%0d", c), out_data_w[0], a_exp);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_inrdy", 128'(in_ready_w), 128'({NI{1'b1}}));
        check("bp_rel_outv", 128'(out_valid_w), 128'(0));
        @(negedge clk);
        in_valid = 1'b0;
        collect(b_exp, "bp_second");

        // Reset in the middle of RUN (cnt = 1 on the LANES=4 instance).
        wait_all_idle();
        in_data = b_in;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_inrdy", 128'(in_ready_w), 128'({NI{1'b1}}));
        check("mrst_outv", 128'(out_valid_w), 128'(0));
        check("mrst_busy", 128'(busy_w), 128'(0));
        check("mrst_data4", out_data_w[2], 128'h0);
        check("mrst_data1", out_data_w[0], 128'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NI; i++) nv[i] = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) if (out_valid_w[i]) nv[i]++;
        end
        for (int i = 0; i < NI; i++) begin
            check($sformatf("mrst_no_out_L%0d", 1 << i), 128'(nv[i]), 128'(0));
        end
        send_check(b_in, b_exp, "mrst_next");

        // Exhaustive byte sweep: byte i of state v carries S(v+i).
        for (int v = 0; v < 256; v++) begin
            for (int i = 0; i < 16; i++) begin
                orig[127 - 8 * i -: 8] = 8'(v + i);
            end
            send_check(fwd_state(orig), orig, $sformatf("sweep%0d", v));
        end

        // Random round trip through forward SubBytes.
        for (int r = 0; r < 1000; r++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            send_check(fwd_state(orig), orig, $sformatf("rt%0d", r));
        end

        // Back-to-back on the LANES=4 instance.
        wait_all_idle();
        out_ready = 1'b1;
        orig = {$urandom, $urandom, $urandom, $urandom};
        in_data = fwd_state(orig);
        in_valid = 1'b1;
        sent = 0;
        rx = 0;
        cyc = 0;
        last_acc = -1;
        pending = 1'b0;
        while (rx < 6 && cyc < 120) begin
            if (pending) begin
                pending = 1'b0;
                if (sent < 6) begin
                    orig = {$urandom, $urandom, $urandom, $urandom};
                    in_data = fwd_state(orig);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid_w[2]) begin
                if (exp_q.size() == 0) begin
                    check("b2b_extra", out_data_w[2], 128'hx);
                end else begin
                    check($sformatf("b2b_data%0d", rx), out_data_w[2], exp_q.pop_front());
                end
                rx++;
            end
            if (in_ready_w[2] && in_valid && sent < 6) begin
                exp_q.push_back(orig);
                if (last_acc >= 0) begin
                    check($sformatf("b2b_gap%0d", sent), 128'(cyc - last_acc), 128'(6));
                end
                last_acc = cyc;
                sent++;
                pending = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("b2b_count", 128'(rx), 128'(6));
        wait_all_idle();

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
